reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 126 ++++++++++++
 tb/tb_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    POWERUP   = 3'd1,
    GAP_CACHE = 3'd2,
    GAP_CPU   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES   = 1024;
  localparam int DEF_SDRAM_POWERUP_CYCLES = 28600;
  localparam int DEF_STAGE_GAP_CYCLES     = 16;
  localparam int DEF_CNT_WIDTH            = 15;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reusable for any
// slow control signal crossing into the clk domain.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for SDRAM controller, cache and CPU behind the system
// PLL: waits for stable lock, the SDRAM power-up time, then releases in order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
  parameter int SDRAM_POWERUP_CYCLES = DEF_SDRAM_POWERUP_CYCLES,
  parameter int STAGE_GAP_CYCLES     = DEF_STAGE_GAP_CYCLES,
  parameter int CNT_WIDTH            = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic soft_rst_req,
  output logic rst_sdram,
  output logic rst_cache,
  output logic rst_cpu,
  output logic ready,
  output logic lock_lost
);

  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PWR_LAST  = CNT_WIDTH'(SDRAM_POWERUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP_CYCLES - 1);

  logic                 lock_s;
  seq_state_e           state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 rst_sdram_q;
  logic                 rst_cache_q;
  logic                 rst_cpu_q;
  logic                 ready_q;
  logic                 lock_lost_q;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d_i(pll_lock),
    .q_o(lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rst_sdram_q <= 1'b1;
      rst_cache_q <= 1'b1;
      rst_cpu_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else if (state_q != WAIT_LOCK && !lock_s) begin
      // Lock dropped after it was stable: restart everything, including POWERUP.
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rst_sdram_q <= 1'b1;
      rst_cache_q <= 1'b1;
      rst_cpu_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            cnt_q   <= '0;
            state_q <= POWERUP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        POWERUP: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q       <= '0;
            rst_sdram_q <= 1'b0;
            state_q     <= GAP_CACHE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP_CACHE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q       <= '0;
            rst_cache_q <= 1'b0;
            state_q     <= GAP_CPU;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP_CPU: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q     <= '0;
            rst_cpu_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          // SDRAM keeps running across a software reset; only cache and CPU restage.
          if (soft_rst_req) begin
            cnt_q       <= '0;
            rst_cache_q <= 1'b1;
            rst_cpu_q   <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= GAP_CACHE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_sdram = rst_sdram_q;
  assign rst_cache = rst_cache_q;
  assign rst_cpu   = rst_cpu_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized checks of the reset sequencer against a
// timeline-based reference model.
module tb_reset_sequencer;

  localparam int L = 4;
  localparam int P = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;
  logic soft_rst_req;
  logic rst_sdram;
  logic rst_cache;
  logic rst_cpu;
  logic ready;
  logic lock_lost;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;

  // Reference model: m_t counts consecutive synchronized-lock-high edges since
  // the last restart; m_s counts edges since a honoured software reset.
  int       m_t;
  int       m_s;
  bit       m_soft;
  bit       m_lost;
  bit [1:0] m_sync;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(L),
    .SDRAM_POWERUP_CYCLES(P),
    .STAGE_GAP_CYCLES(G),
    .CNT_WIDTH(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .soft_rst_req(soft_rst_req),
    .rst_sdram(rst_sdram),
    .rst_cache(rst_cache),
    .rst_cpu(rst_cpu),
    .ready(ready),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_t    = 0;
    m_s    = 0;
    m_soft = 1'b0;
    m_lost = 1'b0;
    m_sync = 2'b00;
  endtask

  task automatic chk_outputs();
    logic e_sd, e_ca, e_cpu;
    e_sd  = m_soft ? 1'b0 : (m_t < L + P);
    e_ca  = m_soft ? (m_s < G) : (m_t < L + P + G);
    e_cpu = m_soft ? (m_s < 2 * G) : (m_t < L + P + 2 * G);
    chk("rst_sdram", rst_sdram, e_sd);
    chk("rst_cache", rst_cache, e_ca);
    chk("rst_cpu", rst_cpu, e_cpu);
    chk("ready", ready, !e_cpu);
    chk("lock_lost", lock_lost, m_lost);
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then check.
  task automatic step();
    bit ls;
    bit running;
    ls      = m_sync[1];
    running = m_soft ? (m_s >= 2 * G) : (m_t >= L + P + 2 * G);
    if (!ls) begin
      if (m_soft || m_t >= L) m_lost = 1'b1;
      m_t    = 0;
      m_soft = 1'b0;
      m_s    = 0;
    end else if (running && soft_rst_req) begin
      m_soft = 1'b1;
      m_s    = 0;
    end else if (m_soft) begin
      if (m_s < 1000) m_s++;
    end else begin
      if (m_t < 1000) m_t++;
    end
    m_sync = {m_sync[0], pll_lock};
    @(posedge clk);
    #1;
    ecnt++;
    chk_outputs();
  endtask

  task automatic areset();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sdram", rst_sdram, 1'b1);
    chk("async_rst_cache", rst_cache, 1'b1);
    chk("async_rst_cpu", rst_cpu, 1'b1);
    chk("async_ready", ready, 1'b0);
    chk("async_lock_lost", lock_lost, 1'b0);
    m_clear();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int sd_fall, ca_fall, cpu_fall, ls_rise, drop_edge, low_cnt;
    bit prev_ls;
    rst          = 1'b1;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    m_clear();
    #1;
    chk("por_rst_sdram", rst_sdram, 1'b1);
    chk("por_ready", ready, 1'b0);
    chk("por_lock_lost", lock_lost, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_outputs();

    // Power-up with lock present from cycle 0.
    ecnt     = 0;
    sd_fall  = -1;
    ca_fall  = -1;
    cpu_fall = -1;
    pll_lock = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (sd_fall < 0 && !rst_sdram) sd_fall = ecnt;
      if (ca_fall < 0 && !rst_cache) ca_fall = ecnt;
      if (cpu_fall < 0 && !rst_cpu) cpu_fall = ecnt;
    end
    chk_int("pwrup_sdram_edge", sd_fall, 14);
    chk_int("pwrup_cache_edge", ca_fall, 16);
    chk_int("pwrup_cpu_edge", cpu_fall, 18);
    chk("pwrup_ready", ready, 1'b1);
    chk("pwrup_lock_lost", lock_lost, 1'b0);

    // Glitchy lock: high 3, low 1, then high.
    areset();
    ecnt    = 0;
    sd_fall = -1;
    ls_rise = -1;
    prev_ls = 1'b0;
    for (int i = 0; i < 26; i++) begin
      pll_lock = (i == 3) ? 1'b0 : 1'b1;
      step();
      if (m_sync[1] && !prev_ls) ls_rise = ecnt;
      prev_ls = m_sync[1];
      if (sd_fall < 0 && !rst_sdram) sd_fall = ecnt;
    end
    chk_int("glitch_lock_rise_edge", ls_rise, 6);
    chk_int("glitch_sdram_offset", sd_fall - ls_rise, 12);

    // Lock loss in RUN, then recovery through the full sequence.
    pll_lock  = 1'b0;
    drop_edge = -1;
    ecnt      = 0;
    for (int i = 0; i < 10 && drop_edge < 0; i++) begin
      step();
      if (rst_sdram) drop_edge = ecnt;
    end
    chk_int("lockloss_latency", drop_edge, 3);
    chk("lockloss_flag", lock_lost, 1'b1);
    pll_lock = 1'b1;
    ecnt     = 0;
    sd_fall  = -1;
    cpu_fall = -1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (sd_fall < 0 && !rst_sdram) sd_fall = ecnt;
      if (cpu_fall < 0 && !rst_cpu) cpu_fall = ecnt;
    end
    chk_int("relock_sdram_edge", sd_fall, 14);
    chk_int("relock_cpu_edge", cpu_fall, 18);
    chk("relock_lock_lost_sticky", lock_lost, 1'b1);

    // Software reset in RUN.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("soft_sdram_stays", rst_sdram, 1'b0);
    chk("soft_cache_asserts", rst_cache, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("soft_ready_back", ready, 1'b1);

    // Software reset during POWERUP is ignored.
    areset();
    for (int i = 0; i < 8; i++) step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("soft_in_powerup_ignored", ready, 1'b1);

    // Software reset on the same edge as lock loss.
    pll_lock = 1'b0;
    step();
    step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("soft_vs_loss_sdram", rst_sdram, 1'b1);
    pll_lock = 1'b1;
    for (int i = 0; i < 22; i++) step();

    // Asynchronous reset in GAP_CPU.
    areset();
    for (int i = 0; i < 17; i++) step();
    chk("gapcpu_cache_released", rst_cache, 1'b0);
    areset();
    for (int i = 0; i < 20; i++) step();

    // Randomized lock glitches and software reset requests.
    low_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (low_cnt > 0) begin
        low_cnt--;
        pll_lock = (low_cnt == 0);
      end else if ($urandom_range(0, 79) == 0) begin
        pll_lock = 1'b0;
        low_cnt  = $urandom_range(1, 3);
      end
      soft_rst_req = ($urandom_range(0, 11) == 0);
      step();
    end
    soft_rst_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
